// File: rtl/pnr_gpio_decoder_pkg.sv
// rtl/pnr_gpio_decoder_pkg.sv - shared constants, FSM encoding and decode helpers
package pnr_pkg;

  localparam int NUM_BINS = 8;
  localparam int BUS_W    = 8;

  localparam logic [3:0] ADDR_ERR = 4'd8;
  localparam logic [3:0] ADDR_TOT = 4'd9;

  typedef enum logic [1:0] {
    ST_WAIT_ZERO  = 2'd0,
    ST_WAIT_EVENT = 2'd1,
    ST_SETTLE     = 2'd2,
    ST_EMIT       = 2'd3
  } pnr_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Only meaningful for a one-hot input; the caller masks the multi-bit case.
  function automatic logic [2:0] onehot_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pnr_gpio_decoder_if.sv
// rtl/pnr_gpio_decoder_if.sv - control, event and histogram readback signals of the decoder
interface pnr_gpio_decoder_if #(
  parameter int COUNT_W = 32
);

  logic               enable;
  logic               hist_clear;
  logic [3:0]         rd_addr;
  logic [COUNT_W-1:0] rd_data;
  logic               evt_valid;
  logic [2:0]         evt_num;
  logic               evt_err;
  logic               busy;

  modport master (
    output enable, hist_clear, rd_addr,
    input  rd_data, evt_valid, evt_num, evt_err, busy
  );

  modport slave (
    input  enable, hist_clear, rd_addr,
    output rd_data, evt_valid, evt_num, evt_err, busy
  );

endinterface

// File: rtl/pnr_gpio_decoder_bus_sync.sv
// rtl/pnr_gpio_decoder_bus_sync.sv - multi-stage synchronizer for the asynchronous photon bus
module pnr_bus_sync
  import pnr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = BUS_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pnr_gpio_decoder.sv
// rtl/pnr_gpio_decoder.sv - photon-number GPIO receiver: settle/one-hot check, event output, histogram
module pnr_gpio_decoder
  import pnr_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int COUNT_W       = 32
) (
  input  logic                ADC_CLK,
  input  logic                rstn_i,
  input  logic [BUS_W-1:0]    gpio_p_i,
  pnr_gpio_decoder_if.slave   bus
);

  localparam int                 CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_DONE = CNT_W'(SETTLE_CYCLES);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

  logic [BUS_W-1:0]   s_bus;
  pnr_state_e         state_q;
  logic [BUS_W-1:0]   cap_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               evt_valid_q;
  logic [2:0]         evt_num_q;
  logic               evt_err_q;
  logic               cap_err;
  logic [2:0]         cap_idx;
  logic [COUNT_W-1:0] bin_q [NUM_BINS];
  logic [COUNT_W-1:0] err_q;
  logic [COUNT_W-1:0] tot_q;
  logic [COUNT_W-1:0] rd_mux_d;
  logic [COUNT_W-1:0] rd_data_q;

  pnr_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (BUS_W)
  ) u_sync (
    .clk_i  (ADC_CLK),
    .rst_ni (rstn_i),
    .d_i    (gpio_p_i),
    .q_o    (s_bus)
  );

  assign cap_err = (popcount8(cap_q) != 4'd1);
  assign cap_idx = cap_err ? 3'd0 : onehot_index(cap_q);

  // Event fields are loaded on the SETTLE->EMIT transition and held until the next event.
  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_WAIT_ZERO;
      cap_q       <= '0;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_num_q   <= 3'd0;
      evt_err_q   <= 1'b0;
    end else begin
      evt_valid_q <= 1'b0;
      if (!bus.enable) begin
        state_q <= ST_WAIT_ZERO;
      end else begin
        case (state_q)
          ST_WAIT_ZERO: begin
            if (s_bus == '0) state_q <= ST_WAIT_EVENT;
          end
          ST_WAIT_EVENT: begin
            if (s_bus != '0) begin
              state_q <= ST_SETTLE;
              cap_q   <= s_bus;
              cnt_q   <= CNT_W'(1);
            end
          end
          ST_SETTLE: begin
            if (s_bus == '0) begin
              state_q <= ST_WAIT_EVENT;
            end else if (s_bus != cap_q) begin
              cap_q <= s_bus;
              cnt_q <= CNT_W'(1);
            end else if (cnt_q == CNT_DONE) begin
              state_q     <= ST_EMIT;
              evt_valid_q <= 1'b1;
              evt_err_q   <= cap_err;
              evt_num_q   <= cap_idx;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_EMIT: begin
            state_q <= ST_WAIT_ZERO;
          end
          default: begin
            state_q <= ST_WAIT_ZERO;
          end
        endcase
      end
    end
  end

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + COUNT_W'(1);
  endfunction

  // Clear takes priority over a coincident increment.
  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
      err_q <= '0;
      tot_q <= '0;
    end else if (bus.hist_clear) begin
      for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
      err_q <= '0;
      tot_q <= '0;
    end else if (evt_valid_q) begin
      tot_q <= sat_inc(tot_q);
      if (evt_err_q) begin
        err_q <= sat_inc(err_q);
      end else begin
        bin_q[evt_num_q] <= sat_inc(bin_q[evt_num_q]);
      end
    end
  end

  always_comb begin
    rd_mux_d = '0;
    if (bus.rd_addr < ADDR_ERR) begin
      rd_mux_d = bin_q[bus.rd_addr[2:0]];
    end else if (bus.rd_addr == ADDR_ERR) begin
      rd_mux_d = err_q;
    end else if (bus.rd_addr == ADDR_TOT) begin
      rd_mux_d = tot_q;
    end
  end

  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_mux_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_num   = evt_num_q;
  assign bus.evt_err   = evt_err_q;
  assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_EMIT);

endmodule

// File: tb/tb_pnr_gpio_decoder.sv
// tb/tb_pnr_gpio_decoder.sv - self-checking bench for pnr_gpio_decoder (32-bit and 4-bit counter builds)
module tb_pnr_gpio_decoder;

  localparam int SYNC   = 2;
  localparam int SETTLE = 2;
  localparam longint MAX_W = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX_N = 15;

  logic       clk;
  logic       rstn;
  logic       enable;
  logic [7:0] gpio;
  logic       hist_clear;
  logic [3:0] rd_addr;

  int n_checks = 0;
  int n_errors = 0;

  pnr_gpio_decoder_if #(.COUNT_W(32)) if_w ();
  pnr_gpio_decoder_if #(.COUNT_W(4))  if_n ();

  assign if_w.enable     = enable;
  assign if_w.hist_clear = hist_clear;
  assign if_w.rd_addr    = rd_addr;
  assign if_n.enable     = enable;
  assign if_n.hist_clear = hist_clear;
  assign if_n.rd_addr    = rd_addr;

  pnr_gpio_decoder #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .COUNT_W(32)) dut_w (
    .ADC_CLK  (clk),
    .rstn_i   (rstn),
    .gpio_p_i (gpio),
    .bus      (if_w)
  );

  pnr_gpio_decoder #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .COUNT_W(4)) dut_n (
    .ADC_CLK  (clk),
    .rstn_i   (rstn),
    .gpio_p_i (gpio),
    .bus      (if_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: s_bus is the pin value delayed SYNC edges; an event fires when an armed
  // window has shown the same non-zero value on SETTLE+1 consecutive edges.
  logic [7:0] pipe [SYNC];
  bit         armed, skip;
  int         run;
  logic [7:0] runval;
  bit         m_valid, m_err;
  int         m_num;
  longint     cw [10];
  longint     cn [10];
  longint     m_rd_w, m_rd_n;

  function automatic longint sat(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC; i++) pipe[i] = 8'h00;
      armed = 0; skip = 0; run = 0; runval = 8'h00;
      m_valid = 0; m_err = 0; m_num = 0;
      for (int i = 0; i < 10; i++) begin cw[i] = 0; cn[i] = 0; end
      m_rd_w = 0; m_rd_n = 0;
    end else begin
      logic [7:0] s;
      m_rd_w = (rd_addr < 10) ? cw[rd_addr] : 0;
      m_rd_n = (rd_addr < 10) ? cn[rd_addr] : 0;
      if (hist_clear) begin
        for (int i = 0; i < 10; i++) begin cw[i] = 0; cn[i] = 0; end
      end else if (m_valid) begin
        int k;
        k = m_err ? 8 : m_num;
        cw[k] = sat(cw[k], MAX_W); cn[k] = sat(cn[k], MAX_N);
        cw[9] = sat(cw[9], MAX_W); cn[9] = sat(cn[9], MAX_N);
      end
      s = pipe[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = gpio;
      m_valid = 0;
      if (!enable) begin
        armed = 0; run = 0; skip = 0;
      end else if (skip) begin
        skip = 0;
      end else if (s == 8'h00) begin
        armed = 1; run = 0;
      end else if (armed) begin
        if (run != 0 && s == runval) run++;
        else begin run = 1; runval = s; end
        if (run == SETTLE + 1) begin
          m_valid = 1;
          m_err = ($countones(s) != 1);
          m_num = 0;
          if (!m_err) for (int b = 0; b < 8; b++) if (s[b]) m_num = b;
          armed = 0; run = 0; skip = 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("evt_valid_w", if_w.evt_valid, m_valid);
    check("evt_num_w",   if_w.evt_num,   m_num);
    check("evt_err_w",   if_w.evt_err,   m_err);
    check("busy_w",      if_w.busy,      (run != 0) || skip);
    check("rd_data_w",   if_w.rd_data,   m_rd_w);
    check("evt_valid_n", if_n.evt_valid, m_valid);
    check("evt_num_n",   if_n.evt_num,   m_num);
    check("rd_data_n",   if_n.rd_data,   m_rd_n);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input longint ew, input longint en);
    rd_addr = a;
    tick(1);
    check($sformatf("lit_rd_w[%0d]", a), if_w.rd_data, ew);
    check($sformatf("lit_rd_n[%0d]", a), if_n.rd_data, en);
  endtask

  task automatic count_pulses(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (if_w.evt_valid) c++;
    end
  endtask

  task automatic wait_evt(output bit got);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (if_w.evt_valid) got = 1;
    end
  endtask

  initial begin
    int c;
    bit got;
    rstn = 1'b0; enable = 1'b1; gpio = 8'h00; hist_clear = 1'b0; rd_addr = 4'd0;
    tick(3);
    check("lit_reset_evt_valid", if_w.evt_valid, 0);
    check("lit_reset_busy",      if_w.busy,      0);
    check("lit_reset_rd_data",   if_w.rd_data,   0);
    check("lit_reset_evt_num",   if_w.evt_num,   0);
    rstn = 1'b1;
    tick(4);

    // single clean event: pulse exactly in the cycle after edge 4
    gpio = 8'h04;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check($sformatf("lit_t1_valid_edge%0d", i), if_w.evt_valid, (i == 4));
      if (i == 4) begin
        check("lit_t1_num", if_w.evt_num, 2);
        check("lit_t1_err", if_w.evt_err, 0);
      end
    end
    gpio = 8'h00; tick(4);
    rd(4'd2, 1, 1);
    rd(4'd9, 1, 1);

    // one-cycle glitch is rejected
    hist_clear = 1'b1; tick(1); hist_clear = 1'b0; tick(2);
    gpio = 8'h01; tick(1); gpio = 8'h00;
    count_pulses(10, c);
    check("lit_t2_pulses", c, 0);
    rd(4'd0, 0, 0);
    rd(4'd9, 0, 0);

    // two bits set -> error event
    gpio = 8'h0C;
    wait_evt(got);
    check("lit_t3_seen", got, 1);
    check("lit_t3_err", if_w.evt_err, 1);
    check("lit_t3_num", if_w.evt_num, 0);
    gpio = 8'h00; tick(4);
    rd(4'd8, 1, 1);
    rd(4'd9, 1, 1);
    rd(4'd2, 0, 0);
    rd(4'd3, 0, 0);

    // long hold gives one event; re-arm after return to zero
    gpio = 8'h80;
    count_pulses(100, c);
    check("lit_t4_pulses_held", c, 1);
    check("lit_t4_num", if_w.evt_num, 7);
    gpio = 8'h00; tick(4);
    gpio = 8'h80;
    count_pulses(10, c);
    check("lit_t4_pulses_again", c, 1);
    gpio = 8'h00; tick(4);
    rd(4'd7, 2, 2);
    rd(4'd9, 3, 3);

    // disable mid-window; bus still high after re-enable is ignored
    gpio = 8'h10; tick(2);
    enable = 1'b0; tick(3); enable = 1'b1;
    count_pulses(10, c);
    check("lit_en_pulses_still_high", c, 0);
    gpio = 8'h00; tick(4);
    gpio = 8'h10;
    count_pulses(10, c);
    check("lit_en_pulses_rearmed", c, 1);
    gpio = 8'h00; tick(4);
    rd(4'd4, 1, 1);

    // clear coincident with increment wins
    gpio = 8'h02;
    wait_evt(got);
    check("lit_t5_seen", got, 1);
    hist_clear = 1'b1; tick(1); hist_clear = 1'b0;
    gpio = 8'h00; tick(4);
    for (int a = 0; a < 10; a++) rd(4'(a), 0, 0);
    rd(4'd12, 0, 0);

    // 20 events on bit 1: 4-bit build saturates at 15
    for (int e = 0; e < 20; e++) begin
      gpio = 8'h02; tick(7);
      gpio = 8'h00; tick(4);
    end
    rd(4'd1, 20, 15);
    rd(4'd9, 20, 15);
    rd(4'd8, 0, 0);

    // reset during SETTLE discards the window and clears everything
    rd_addr = 4'd1;
    gpio = 8'h08; tick(3);
    check("lit_t6_busy_settle", if_w.busy, 1);
    rstn = 1'b0; tick(2);
    check("lit_t6_rst_valid",  if_w.evt_valid, 0);
    check("lit_t6_rst_num",    if_w.evt_num,   0);
    check("lit_t6_rst_err",    if_w.evt_err,   0);
    check("lit_t6_rst_busy",   if_w.busy,      0);
    check("lit_t6_rst_rd_w",   if_w.rd_data,   0);
    check("lit_t6_rst_rd_n",   if_n.rd_data,   0);
    gpio = 8'h00; rstn = 1'b1;
    count_pulses(6, c);
    check("lit_t6_pulses_after_rst", c, 0);
    rd(4'd1, 0, 0);
    rd(4'd9, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
